pipe_stage_buf: RTL and testbench

//  Parametrised inter-stage pipeline buffer, replacing the fixed per-stage registers (if_id, id_ex, ex_mem...).

---
 rtl/pipe_stage_buf_pkg.sv | 37 +++
 rtl/pipe_stage_buf_sat_counter.sv | 20 ++
 rtl/pipe_stage_buf.sv | 113 +++++++++++
 tb/tb_pipe_stage_buf.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared types for the inter-stage pipeline buffers: FSM state encoding,
// per-stage payload layouts with their NOP (bubble) values, and pause vector indices.
package pipe_stage_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKIDF = 2'd2
    } pipe_state_t;

    localparam int PAUSE_IF  = 0;
    localparam int PAUSE_ID  = 1;
    localparam int PAUSE_EX  = 2;
    localparam int PAUSE_MEM = 3;
    localparam int PAUSE_WB  = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    typedef struct packed {
        logic [2:0]  alusel;
        logic [7:0]  aluop;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  waddr;
        logic        wen;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [14:0] rsvd;
    } id_ex_t;

    localparam if_id_t IF_ID_BUBBLE = '0;
    localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline stage register with valid/ready handshake, global pause
// vector, flush, bubble insertion on drain, optional 2-entry skid and bubble counter.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int                DATA_W  = 160,
    parameter int                PAUSE_W = 6,
    parameter int                STAGE   = 2,
    parameter logic [DATA_W-1:0] BUBBLE  = '0,
    parameter int                SKID    = 1,
    parameter int                CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PAUSE_W-1:0] pause,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam logic [1:0] S_EMPTY = EMPTY;
    localparam logic [1:0] S_FULL  = FULL;
    localparam logic [1:0] S_SKIDF = SKIDF;

    // Handshake: a beat transfers on a side only when valid and ready are both
    // high at the rising edge and that side's stage is not paused.
    logic [1:0]        state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;
    logic              out_pause;
    logic              in_pause;

    assign in_pause  = pause[STAGE];
    assign out_pause = pause[STAGE+1];
    assign out_valid = (state != S_EMPTY);
    assign out_data  = main_q;

    generate
        if (SKID != 0) begin : g_skid
            // Decoded purely from the state flop: no path from out_ready/pause.
            assign in_ready = (state != S_SKIDF);
        end else begin : g_noskid
            assign in_ready = (state == S_EMPTY) | (out_ready & ~out_pause);
        end
    endgenerate

    assign in_fire  = in_valid & in_ready & ~in_pause;
    assign out_fire = out_valid & out_ready & ~out_pause;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state  <= S_EMPTY;
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_fire) begin
                        state  <= S_FULL;
                        main_q <= in_data;
                    end
                end
                S_FULL: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        state  <= S_SKIDF;
                        skid_q <= in_data;
                    end else if (out_fire) begin
                        state  <= S_EMPTY;
                        main_q <= BUBBLE;
                    end
                end
                S_SKIDF: begin
                    if (out_fire) begin
                        state  <= S_FULL;
                        main_q <= skid_q;
                        skid_q <= BUBBLE;
                    end
                end
                default: begin
                    state  <= S_EMPTY;
                    main_q <= BUBBLE;
                    skid_q <= BUBBLE;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~out_valid),
        .clr   (cnt_clr),
        .count (bubble_cnt)
    );

    a_bubble_when_empty : assert property (@(posedge clk) disable iff (rst)
        !out_valid |-> (out_data == BUBBLE));
    a_no_skid_state : assert property (@(posedge clk) disable iff (rst)
        (SKID == 0) |-> (state != S_SKIDF));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a SKID=1 instance for streaming, skid,
// stall and flush, and a SKID=0 / CNT_W=4 instance for saturation and comb ready.
module tb_pipe_stage_buf;

    localparam int                DW  = 16;
    localparam int                PW  = 6;
    localparam logic [DW-1:0]     BUB = 16'h0BAD;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] pause;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          cnt_clr;
    logic [31:0]   bubble_cnt;

    logic          s_rst;
    logic          s_in_valid;
    logic          s_in_ready;
    logic [DW-1:0] s_in_data;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [DW-1:0] s_out_data;
    logic          s_cnt_clr;
    logic [3:0]    s_bubble_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(
        .DATA_W(DW), .PAUSE_W(PW), .STAGE(2), .BUBBLE(BUB), .SKID(1), .CNT_W(32)
    ) u_dut (
        .clk(clk), .rst(rst), .pause(pause), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cnt_clr(cnt_clr), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_buf #(
        .DATA_W(DW), .PAUSE_W(PW), .STAGE(2), .BUBBLE(BUB), .SKID(0), .CNT_W(4)
    ) u_dut_s (
        .clk(clk), .rst(s_rst), .pause(pause), .flush(flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .cnt_clr(s_cnt_clr), .bubble_cnt(s_bubble_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; pause = '0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        s_rst = 1'b1; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0; s_cnt_clr = 1'b0;

        // 1: reset
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, BUB);
        check("rst_ready", in_ready, 1);
        check("rst_cnt", bubble_cnt, 0);

        // 2: back-to-back stream, one-cycle latency
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_data", out_data, i);
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", out_valid, 0);
        check("drain_data", out_data, BUB);
        check("stream_cnt", bubble_cnt, 1);

        // 3: skid capture and ordered release
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00A1;
        tick();
        check("skid_a_data", out_data, 16'h00A1);
        check("skid_a_ready", in_ready, 1);
        in_data = 16'h00B2;
        tick();
        check("skidf_ready", in_ready, 0);
        check("skidf_data", out_data, 16'h00A1);
        out_ready = 1'b1; in_data = 16'h00C3;
        tick();
        check("skid_b_data", out_data, 16'h00B2);
        check("skid_b_ready", in_ready, 1);
        tick();
        check("skid_c_data", out_data, 16'h00C3);
        in_valid = 1'b0;
        tick();
        check("skid_end_valid", out_valid, 0);
        check("skid_cnt", bubble_cnt, 2);

        // 4: stalls
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00A1;
        tick();
        in_data = 16'h00D4; out_ready = 1'b1; pause = 6'b001100;
        tick();
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, 16'h00A1);
        pause = 6'b000100;
        tick();
        check("legacy_valid", out_valid, 0);
        check("legacy_data", out_data, BUB);
        check("legacy_cnt0", bubble_cnt, 3);
        tick();
        check("legacy_noacc", out_valid, 0);
        check("legacy_cnt1", bubble_cnt, 4);
        pause = '0; in_valid = 1'b0;

        // 5: flush while in SKIDF with new input offered
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00E5;
        tick();
        in_data = 16'h00F6;
        tick();
        check("flush_pre_ready", in_ready, 0);
        flush = 1'b1; in_data = 16'h0077;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_data", out_data, BUB);
        check("flush_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();
        check("flush_empty", out_valid, 0);
        check("flush_cnt", bubble_cnt, 6);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_cnt", bubble_cnt, 0);

        // 6: 4-bit counter saturation and clear
        s_rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("sat_cnt", s_bubble_cnt, 15);
        s_cnt_clr = 1'b1;
        tick();
        s_cnt_clr = 1'b0;
        check("sat_clr", s_bubble_cnt, 0);
        tick();
        check("sat_resume", s_bubble_cnt, 1);

        // SKID=0: combinational ready
        s_in_valid = 1'b1; s_in_data = 16'h0005; s_out_ready = 1'b0;
        tick();
        check("ns_full_data", s_out_data, 16'h0005);
        check("ns_ready_lo", s_in_ready, 0);
        s_in_data = 16'h0006;
        tick();
        check("ns_hold_data", s_out_data, 16'h0005);
        s_out_ready = 1'b1;
        #1;
        check("ns_ready_hi", s_in_ready, 1);
        tick();
        check("ns_pass_data", s_out_data, 16'h0006);
        s_in_valid = 1'b0;
        tick();
        check("ns_drain_valid", s_out_valid, 0);
        check("ns_drain_data", s_out_data, BUB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
